// File: rtl/hex_pkg.sv
// Shared types and constants for the time-multiplexed seven-segment display controller.
package hex_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    WAIT,
    LOAD
  } scan_state_t;

  localparam logic [6:0] BLANK      = 7'h7F;
  localparam int         NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

endpackage

// File: rtl/hexdecoder.sv
// Combinational hex-to-seven-segment decoder, active-low, bit 0 = segment a.
module hexdecoder (
  input  logic [3:0] c,
  output logic [6:0] display,
  output logic       led
);

  always_comb begin
    display = 7'h7F;
    case (c)
      4'h0: display = 7'b1000000;
      4'h1: display = 7'b1111001;
      4'h2: display = 7'b0100100;
      4'h3: display = 7'b0110000;
      4'h4: display = 7'b0011001;
      4'h5: display = 7'b0010010;
      4'h6: display = 7'b0000010;
      4'h7: display = 7'b1111000;
      4'h8: display = 7'b0000000;
      4'h9: display = 7'b0010000;
      4'hA: display = 7'b0001000;
      4'hB: display = 7'b0000011;
      4'hC: display = 7'b1000110;
      4'hD: display = 7'b0100001;
      4'hE: display = 7'b0000110;
      4'hF: display = 7'b0001110;
      default: display = 7'h7F;
    endcase
  end

  // Lit for the letter digits A..F.
  assign led = (c > 4'd9);

endmodule

// File: rtl/hex_scan_controller.sv
// Six-digit HEX display driver: a single shared decoder is time-multiplexed across
// the digit registers, refreshing one digit every TICK_DIV+1 cycles.
module hex_scan_controller
  import hex_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clr,
  input  logic       wr_valid,
  input  logic [2:0] wr_digit,
  input  logic [3:0] wr_value,
  output logic       wr_ready,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       busy
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  scan_state_t            state, state_nxt;
  digit_idx_t             idx, idx_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  logic [3:0]             val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  en;
  logic [6:0]             seg [NUM_DIGITS];

  logic [3:0]             dec_in;
  logic [6:0]             dec_seg;
  logic                   led_unused;
  logic                   wr_fire;

  assign wr_ready = (state != CLEAR) && !clr;
  assign busy     = (state == CLEAR);
  assign wr_fire  = wr_valid && wr_ready;
  assign dec_in   = val[idx];

  hexdecoder u_dec (
    .c       (dec_in),
    .display (dec_seg),
    .led     (led_unused)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= CLEAR;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    // clr is only honoured outside CLEAR so a running clear sequence is never restarted.
    if (clr && state != CLEAR) begin
      state_nxt = CLEAR;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == LAST_DIGIT) begin
            state_nxt = WAIT;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end else begin
            idx_nxt = idx + digit_idx_t'(1);
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          state_nxt = WAIT;
          idx_nxt   = (idx == LAST_DIGIT) ? '0 : idx + digit_idx_t'(1);
        end
        default: begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val[i] <= '0;
        en[i]  <= 1'b0;
        seg[i] <= BLANK;
      end
    end else if (state == CLEAR) begin
      val[idx] <= '0;
      en[idx]  <= 1'b0;
      seg[idx] <= BLANK;
    end else begin
      // LOAD reads val before this edge, so a colliding write shows on the next visit.
      if (state == LOAD && !clr) begin
        seg[idx] <= en[idx] ? dec_seg : BLANK;
      end
      if (wr_fire && wr_digit < 3'(NUM_DIGITS)) begin
        val[wr_digit] <= wr_value;
        en[wr_digit]  <= 1'b1;
      end
    end
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];

endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller: frame-position model checked every cycle plus
// hand-computed display patterns for each scenario.
module tb_hex_scan_controller;

  localparam int TD    = 4;
  localparam int FRAME = 6 * (TD + 1);

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       clr      = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_digit = '0;
  logic [3:0] wr_value = '0;
  logic       wr_ready, busy;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0] hex_act [6];

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scan_controller #(.TICK_DIV(TD)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clr      (clr),
    .wr_valid (wr_valid),
    .wr_digit (wr_digit),
    .wr_value (wr_value),
    .wr_ready (wr_ready),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .busy     (busy)
  );

  assign hex_act[0] = HEX0;
  assign hex_act[1] = HEX1;
  assign hex_act[2] = HEX2;
  assign hex_act[3] = HEX3;
  assign hex_act[4] = HEX4;
  assign hex_act[5] = HEX5;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: position t counts cycles since the clear sequence ended; digit (t/(TD+1))%6
  // is refreshed whenever t lands on the last slot of its TD+1 window.
  int         clear_left = 6;
  int         t = 0;
  bit         started = 1'b0;
  logic [3:0] mval [6];
  logic       men  [6];
  logic [6:0] mseg [6];

  initial begin
    for (int i = 0; i < 6; i++) begin
      mval[i] = '0;
      men[i]  = 1'b0;
      mseg[i] = 7'h7F;
    end
  end

  always @(posedge CLOCK_50) begin : model
    int d;
    started = 1'b1;
    if (!resetn) begin
      clear_left = 6;
      t = 0;
      for (int i = 0; i < 6; i++) begin
        mval[i] = '0;
        men[i]  = 1'b0;
        mseg[i] = 7'h7F;
      end
    end else if (clear_left > 0) begin
      mval[6 - clear_left] = '0;
      men[6 - clear_left]  = 1'b0;
      mseg[6 - clear_left] = 7'h7F;
      clear_left--;
      t = 0;
    end else if (clr) begin
      clear_left = 6;
    end else begin
      if (t % (TD + 1) == TD) begin
        d = (t / (TD + 1)) % 6;
        mseg[d] = men[d] ? SEG_TAB[mval[d]] : 7'h7F;
      end
      if (wr_valid && wr_digit < 3'd6) begin
        mval[wr_digit] = wr_value;
        men[wr_digit]  = 1'b1;
      end
      t++;
    end
  end

  always @(negedge CLOCK_50) begin
    if (started) begin
      #2;
      chk("wr_ready", int'(wr_ready), int'(clear_left == 0 && !clr));
      chk("busy", int'(busy), int'(clear_left > 0));
      for (int i = 0; i < 6; i++)
        chk($sformatf("HEX%0d", i), int'(hex_act[i]), int'(mseg[i]));
    end
  end

  logic [6:0] lit [6];

  initial begin
    int d;
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #3;
    chk("rst_busy", int'(busy), 1);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_HEX3", int'(HEX3), 'h7F);
    resetn = 1'b1;

    for (int i = 1; i <= 6; i++) begin
      @(negedge CLOCK_50);
      #3;
      if (i < 6) begin
        chk("rel_busy", int'(busy), 1);
        chk("rel_wr_ready", int'(wr_ready), 0);
      end else begin
        chk("rel_busy_done", int'(busy), 0);
        chk("rel_wr_ready_up", int'(wr_ready), 1);
      end
    end

    // single write of digit 2
    @(negedge CLOCK_50);
    wr_valid = 1'b1; wr_digit = 3'd2; wr_value = 4'h0;
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    repeat (FRAME) @(negedge CLOCK_50);
    #3;
    chk("single_HEX2", int'(HEX2), 'h40);
    chk("single_HEX0", int'(HEX0), 'h7F);
    chk("single_HEX5", int'(HEX5), 'h7F);

    // six back-to-back writes
    lit = '{7'b0000000, 7'b0001000, 7'b0001110, 7'b1111001, 7'b1000000, 7'b0000000};
    @(negedge CLOCK_50);
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_digit = 3'(i);
      case (i)
        0: wr_value = 4'h8;
        1: wr_value = 4'hA;
        2: wr_value = 4'hF;
        3: wr_value = 4'h1;
        4: wr_value = 4'h0;
        default: wr_value = 4'h8;
      endcase
      #3;
      chk("b2b_wr_ready", int'(wr_ready), 1);
      @(negedge CLOCK_50);
    end
    wr_valid = 1'b0;
    repeat (FRAME + 1) @(negedge CLOCK_50);
    #3;
    for (int i = 0; i < 6; i++)
      chk($sformatf("full_HEX%0d", i), int'(hex_act[i]), int'(lit[i]));

    // write colliding with LOAD of the same digit
    d = -1;
    for (int k = 0; k < 2 * (TD + 1) && d < 0; k++) begin
      @(negedge CLOCK_50);
      if (clear_left == 0 && t % (TD + 1) == TD) d = (t / (TD + 1)) % 6;
    end
    chk("collision_found", int'(d >= 0), 1);
    if (d < 0) d = 0;
    wr_valid = 1'b1; wr_digit = 3'(d); wr_value = 4'h3;
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    #3;
    chk("collide_old", int'(hex_act[d]), int'(lit[d]));
    repeat (FRAME) @(negedge CLOCK_50);
    #3;
    chk("collide_new", int'(hex_act[d]), 'h30);
    lit[d] = 7'b0110000;

    // out-of-range digit
    @(negedge CLOCK_50);
    wr_valid = 1'b1; wr_digit = 3'd7; wr_value = 4'h5;
    #3;
    chk("oor_wr_ready", int'(wr_ready), 1);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    repeat (2 * FRAME) @(negedge CLOCK_50);
    #3;
    for (int i = 0; i < 6; i++)
      chk($sformatf("oor_HEX%0d", i), int'(hex_act[i]), int'(lit[i]));

    // clr with a simultaneous write, then clr again during CLEAR
    @(negedge CLOCK_50);
    clr = 1'b1; wr_valid = 1'b1; wr_digit = 3'd1; wr_value = 4'h9;
    #3;
    chk("clr_wr_ready", int'(wr_ready), 0);
    @(negedge CLOCK_50);
    clr = 1'b0; wr_valid = 1'b0;
    #3;
    chk("clr_busy", int'(busy), 1);
    @(negedge CLOCK_50);
    clr = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    #3;
    chk("clr_busy_done", int'(busy), 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("clr_HEX%0d", i), int'(hex_act[i]), 'h7F);
    repeat (FRAME + 1) @(negedge CLOCK_50);
    #3;
    for (int i = 0; i < 6; i++)
      chk($sformatf("clr_en_HEX%0d", i), int'(hex_act[i]), 'h7F);

    @(negedge CLOCK_50);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
